// File: rtl/sc_fsm_eval_ctrl.sv
// sc_fsm_eval_ctrl: binary-to-SC-to-binary sequencer driving an FSM-based stochastic function unit
module sc_fsm_eval_ctrl #(
  parameter int LEN = 255,
  parameter int WARMUP = 16,
  parameter logic [7:0] SEED = 8'h01,
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    value,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] result,
  output logic          fsm_rst,
  output logic          fsm_x,
  input  logic          fsm_y
);
  typedef enum logic [2:0] {IDLE, CLEAR, WARM, MEAS, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d, value_q, value_d, lfsr_nx;
  logic [15:0] cnt_q, cnt_d;
  logic [CW-1:0] ones_q, ones_d, result_q, result_d;
  logic last_w, last_m;
  assign lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign last_w = cnt_q == 16'(WARMUP - 1);
  assign last_m = cnt_q == 16'(LEN - 1);
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    value_d = value_q;
    cnt_d = cnt_q;
    ones_d = ones_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        value_d = start ? value : value_q;
        state_d = start ? CLEAR : IDLE;
      end
      CLEAR: begin
        lfsr_d = SEED;
        cnt_d = '0;
        ones_d = '0;
        state_d = (WARMUP == 0) ? MEAS : WARM;
      end
      WARM: begin
        lfsr_d = lfsr_nx;
        cnt_d = last_w ? '0 : cnt_q + 16'd1;
        state_d = abort ? IDLE : last_w ? MEAS : WARM;
      end
      MEAS: begin
        lfsr_d = lfsr_nx;
        cnt_d = cnt_q + 16'd1;
        ones_d = ones_q + CW'(fsm_y);
        result_d = (last_m && !abort) ? ones_d : result_q;
        state_d = abort ? IDLE : last_m ? DONE : MEAS;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      value_q <= '0;
      cnt_q <= '0;
      ones_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      value_q <= value_d;
      cnt_q <= cnt_d;
      ones_q <= ones_d;
      result_q <= result_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = result_q;
  assign fsm_rst = state_q == IDLE || state_q == CLEAR;
  // Comparator over a full LFSR period yields exactly value ones
  assign fsm_x = (state_q == WARM || state_q == MEAS) && lfsr_q <= value_q;
endmodule

// File: tb/tb_sc_fsm_eval_ctrl.sv
// tb_sc_fsm_eval_ctrl: directed checks of sc_fsm_eval_ctrl with WARMUP=0 and WARMUP=16 instances
module tb_sc_fsm_eval_ctrl;
  logic clk = 0, reset = 1, abort = 0, start_a = 0, start_b = 0, sel = 0, use_sat = 0;
  logic [7:0] value = 0;
  logic busy_a, done_a, rst_a, x_a, busy_b, done_b, rst_b, x_b, y_b;
  logic [7:0] result_a, result_b;
  logic [5:0] sat_q = 6'd32;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  sc_fsm_eval_ctrl #(.LEN(255), .WARMUP(0), .SEED(8'h01)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort), .value(value),
    .busy(busy_a), .done(done_a), .result(result_a), .fsm_rst(rst_a), .fsm_x(x_a), .fsm_y(x_a));
  sc_fsm_eval_ctrl #(.LEN(255), .WARMUP(16), .SEED(8'h01)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort), .value(value),
    .busy(busy_b), .done(done_b), .result(result_b), .fsm_rst(rst_b), .fsm_x(x_b), .fsm_y(y_b));
  always @(posedge clk)
    sat_q <= rst_b ? 6'd32 : x_b ? (sat_q == 6'd63 ? sat_q : sat_q + 6'd1)
                                  : (sat_q == 6'd0 ? sat_q : sat_q - 6'd1);
  assign y_b = use_sat ? sat_q[5] : x_b;
  wire busy_s = sel ? busy_b : busy_a;
  wire done_s = sel ? done_b : done_a;
  wire rst_s = sel ? rst_b : rst_a;
  wire [7:0] result_s = sel ? result_b : result_a;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int ref_sat(input logic [7:0] v);
    logic [7:0] lf = 8'h01;
    logic [5:0] c = 6'd32;
    int ones = 0;
    for (int i = 0; i < 16 + 255; i++) begin
      if (i >= 16) ones += int'(c[5]);
      if (lf <= v) c = (c == 6'd63) ? c : c + 6'd1;
      else c = (c == 6'd0) ? c : c - 6'd1;
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    end
    return ones;
  endfunction
  task automatic run(input bit s, input logic [7:0] v, input int exp_cyc, input int exp_res,
                     input bit poke, input string tag);
    int cyc = 1, dn = 0, dc = 0;
    bit p;
    sel = s;
    value = v;
    start_a = !s;
    start_b = s;
    tick;
    start_a = 0;
    start_b = 0;
    check({tag, " clear busy"}, 32'(busy_s), 1);
    check({tag, " clear fsm_rst"}, 32'(rst_s), 1);
    while (busy_s && cyc < 1000) begin
      if (cyc == 2) check({tag, " fsm_rst low"}, 32'(rst_s), 0);
      if (done_s) begin
        dn++;
        dc = cyc;
      end
      p = poke && (cyc == 1 || cyc == 5 || cyc == 100 || cyc == exp_cyc);
      start_a = p && !s;
      start_b = p && s;
      tick;
      cyc++;
    end
    start_a = 0;
    start_b = 0;
    check({tag, " idle cycle"}, 32'(cyc), 32'(exp_cyc + 1));
    check({tag, " done cycle"}, 32'(dc), 32'(exp_cyc));
    check({tag, " done pulses"}, 32'(dn), 1);
    check({tag, " result"}, 32'(result_s), 32'(exp_res));
  endtask
  initial begin
    int dn, r;
    #3;
    check("reset busy", 32'(busy_a), 0);
    check("reset done", 32'(done_a), 0);
    check("reset result", 32'(result_a), 0);
    check("reset fsm_rst", 32'(rst_a), 1);
    check("reset fsm_x", 32'(x_a), 0);
    #9 reset = 0;
    tick;
    run(0, 8'd0, 257, 0, 0, "w0 v0");
    run(1, 8'd255, 273, 255, 1, "v255 poke");
    run(1, 8'd37, 273, 37, 0, "v37 b2b");
    run(1, 8'd128, 273, 128, 0, "v128");
    value = 8'd200;
    start_b = 1;
    tick;
    start_b = 0;
    repeat (99) tick;
    abort = 1;
    tick;
    abort = 0;
    check("abort busy", 32'(busy_b), 0);
    check("abort fsm_rst", 32'(rst_b), 1);
    check("abort result", 32'(result_b), 128);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      dn += int'(done_b) + int'(busy_b);
      tick;
    end
    check("abort quiet", 32'(dn), 0);
    sel = 0;
    value = 8'd128;
    start_a = 1;
    tick;
    start_a = 0;
    repeat (50) tick;
    #2 reset = 1;
    #1;
    check("async busy", 32'(busy_a), 0);
    check("async done", 32'(done_a), 0);
    check("async result", 32'(result_a), 0);
    check("async fsm_rst", 32'(rst_a), 1);
    check("async fsm_x", 32'(x_a), 0);
    #2 reset = 0;
    tick;
    run(0, 8'd0, 257, 0, 0, "rerun v0");
    use_sat = 1;
    r = ref_sat(8'd128);
    run(1, 8'd128, 273, r, 0, "sat run1");
    run(1, 8'd128, 273, r, 0, "sat run2");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
